alu_32bit: RTL and testbench
============================

# alu_32bit

Registered 32-bit arithmetic/logic unit with carry, zero and negative status flags. It sits in the datapath as a single-cycle-latency execute stage. Each cycle it takes two operands and a 3-bit opcode, computes one of eight operations, and registers the result and flags on the next rising clock edge.

## Interface
Parameters:
- None. Width is fixed at 32.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  32  operand A
- b  input  32  operand B; b[4:0] is the shift amount for shift ops
- sel  input  3  opcode
- out  output  32  registered result
- c  output  1  registered carry flag
- z  output  1  registered zero flag
- n  output  1  registered negative flag
- v  output  1  registered signed-overflow flag; present only with ALU32_OVF_EN

## Operation
Opcodes:
- 000 ADD: out = a + b; c = carry-out of bit 31.
- 001 SUB: out = a + ~b + 1; c = carry-out (1 = no borrow, i.e. a >= b unsigned).
- 010 AND: out = a & b; c = 0.
- 011 OR: out = a | b; c = 0.
- 100 XOR: out = a ^ b; c = 0.
- 101 NOR: out = ~(a | b); c = 0.
- 110 SLL: out = a << b[4:0]; c = last bit shifted out (a[32-sh]); c = 0 when sh = 0.
- 111 SRL (logical): out = a >> b[4:0]; c = a[sh-1]; c = 0 when sh = 0.

Flags and arithmetic rules:
- z = (result == 0) and n = result[31], for every opcode.
- All arithmetic is modulo 2^32 and unsigned for c.
- b[31:5] is ignored by shifts.
- No undefined opcodes exist; all 8 encodings are defined.

## Timing
- Combinational compute; result and flags are captured into registers on the rising clk edge. Latency is 1 cycle, throughput is 1 op per cycle.
- There is no handshake: inputs are sampled every edge.
- rst_n low, asynchronously and at any time including mid-stream, forces out = 0, c = 0, z = 1, n = 0, v = 0. Outputs hold these values until the first rising edge after rst_n deasserts.
- Inputs changing between edges do not affect outputs until the next edge.

## Configuration
- ALU32_OVF_EN defined: port v exists.
  - ADD: v = (a[31] == b[31]) && (out[31] != a[31]).
  - SUB: v = (a[31] != b[31]) && (out[31] != a[31]).
  - v = 0 for all other opcodes.
- ALU32_OVF_EN undefined: port v and its register are absent; all other behaviour is identical.

## Structure
- Shared package alu_32bit_pkg holds the opcode constants (OP_ADD … OP_SRL, 3 bits) and the data width constant (32).
- Sub-module alu_32bit_core is purely combinational: a, b, sel → result, c, v.
- The top-level alu_32bit computes z and n and holds the output registers with async reset.

## Test plan
All vectors with a = 0xFFFFFFFF, b = 0x80000001, results checked one cycle after applying sel:
- Reset: assert rst_n = 0 mid-run → out = 0, c = 0, z = 1, n = 0 immediately, without waiting for a clock edge.
- sel = 000 → 0x80000000, c = 1, n = 1, z = 0. sel = 001 → 0x7FFFFFFE, c = 1, n = 0.
- sel = 010 → 0x80000001, n = 1. sel = 011 → 0xFFFFFFFF. sel = 100 → 0x7FFFFFFE. sel = 101 → 0x00000000, z = 1. c = 0 for all four.
- sel = 110 → 0xFFFFFFFE, c = 1. sel = 111 → 0x7FFFFFFF, c = 1, n = 0.
- Overflow (ALU32_OVF_EN): a = 0x7FFFFFFF, b = 1, sel = 000 → 0x80000000, v = 1, c = 0, n = 1. Same operands with sel = 001 → 0x7FFFFFFE, v = 0, c = 1.
- Shift by zero: a = 0x12345678, b = 0x00000020 (b[4:0] = 0), sel = 110 → out = 0x12345678, c = 0.

Source files
------------

// File: rtl/alu_32bit_pkg.sv
// Shared constants for the 32-bit ALU: data width, shift-amount width and opcode encodings.
// Imported by alu_32bit_core and alu_32bit.
package alu_32bit_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = $clog2(DATA_W);
    localparam int OP_W    = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOR = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              c;
        logic              z;
        logic              n;
    } alu_flags_t;

endpackage

// File: rtl/alu_32bit_core.sv
// Purely combinational ALU datapath: a, b, sel -> result, carry and (with ALU32_OVF_EN) signed overflow.
module alu_32bit_core
    import alu_32bit_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   sel,
    output logic [DATA_W-1:0] result,
`ifdef ALU32_OVF_EN
    output logic              v,
`endif
    output logic              c
);

    logic [SHAMT_W-1:0] w_sh;
    logic [DATA_W:0]    w_add;
    logic [DATA_W:0]    w_sub;
    logic [DATA_W:0]    w_sll;
    logic [DATA_W:0]    w_srl;

    assign w_sh  = b[SHAMT_W-1:0];
    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
    // An extra guard bit catches the last bit shifted out; it is 0 for a zero shift.
    assign w_sll = {1'b0, a} << w_sh;
    assign w_srl = {a, 1'b0} >> w_sh;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result = '0;
        c      = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD: {c, result} = w_add;
            OP_SUB: {c, result} = w_sub;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOR: result = ~(a | b);
            OP_SLL: {c, result} = w_sll;
            OP_SRL: {result, c} = w_srl;
            default: begin
                result = '0;
                c      = 1'b0;
            end
        endcase
    end

`ifdef ALU32_OVF_EN
    always_comb begin
        v = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD:  v = (a[DATA_W-1] == b[DATA_W-1]) && (w_add[DATA_W-1] != a[DATA_W-1]);
            OP_SUB:  v = (a[DATA_W-1] != b[DATA_W-1]) && (w_sub[DATA_W-1] != a[DATA_W-1]);
            default: v = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_32bit.sv
// Registered 32-bit ALU execute stage: one-cycle latency, async active-low reset.
// Define ALU32_OVF_EN to add the registered signed-overflow flag output v.
module alu_32bit
    import alu_32bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   sel,
    output logic [DATA_W-1:0] out,
    output logic              c,
    output logic              z,
`ifdef ALU32_OVF_EN
    output logic              v,
`endif
    output logic              n
);

    alu_flags_t w_next;
    alu_flags_t r_state;
    logic [DATA_W-1:0] w_result;
    logic              w_c;

`ifdef ALU32_OVF_EN
    logic w_v;
    logic r_v;
`endif

    alu_32bit_core u_core (
        .a      (a),
        .b      (b),
        .sel    (sel),
        .result (w_result),
`ifdef ALU32_OVF_EN
        .v      (w_v),
`endif
        .c      (w_c)
    );

    assign w_next.result = w_result;
    assign w_next.c      = w_c;
    assign w_next.z      = (w_result == '0);
    assign w_next.n      = w_result[DATA_W-1];

    // Reset value reports a zero result, so z is 1 while everything else is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '{result: '0, c: 1'b0, z: 1'b1, n: 1'b0};
        end else begin
            // NOTE: registers use non-blocking assignment so all state updates at the same edge.
            r_state <= w_next;
        end
    end

`ifdef ALU32_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
        end else begin
            r_v <= w_v;
        end
    end
    assign v = r_v;
`endif

    assign out = r_state.result;
    assign c   = r_state.c;
    assign z   = r_state.z;
    assign n   = r_state.n;

endmodule

// File: tb/tb_alu_32bit.sv
// Self-checking bench for alu_32bit: directed vectors, async reset, hold and randomized ops vs a reference model.
// Build with ALU32_OVF_EN defined to also check the overflow flag v.
module tb_alu_32bit;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] out;
    logic        c;
    logic        z;
    logic        n;
`ifdef ALU32_OVF_EN
    logic        v;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] out;
        logic        c;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    alu_32bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sel   (sel),
        .out   (out),
        .c     (c),
        .z     (z),
`ifdef ALU32_OVF_EN
        .v     (v),
`endif
        .n     (n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_checks++;
        if (obs !== exp_val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_val);
        end
    endtask

    // Reference model in plain wide arithmetic, straight from the opcode table.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb, input logic [2:0] ms);
        exp_t            e;
        longint unsigned ua;
        longint unsigned ub;
        longint          sa;
        longint          sb;
        longint          sr;
        int              ia;
        int              ib;
        int              sh;
        ua = 64'(ma);
        ub = 64'(mb);
        ia = $signed(ma);
        ib = $signed(mb);
        sa = 64'(ia);
        sb = 64'(ib);
        sh = int'(mb[4:0]);
        e.c = 1'b0;
        e.v = 1'b0;
        case (ms)
            3'd0: begin
                e.out = 32'(ua + ub);
                e.c   = (ua + ub) > 64'hFFFF_FFFF;
                sr    = sa + sb;
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                e.out = ma - mb;
                e.c   = (ma >= mb);
                sr    = sa - sb;
                e.v   = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: e.out = ma & mb;
            3'd3: e.out = ma | mb;
            3'd4: e.out = ma ^ mb;
            3'd5: e.out = ~(ma | mb);
            3'd6: begin
                e.out = ma << sh;
                e.c   = (sh != 0) ? ma[32-sh] : 1'b0;
            end
            default: begin
                e.out = ma >> sh;
                e.c   = (sh != 0) ? ma[sh-1] : 1'b0;
            end
        endcase
        e.z = (e.out == 32'd0);
        e.n = e.out[31];
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".out"}, out, e.out);
        check({tag, ".c"}, 32'(c), 32'(e.c));
        check({tag, ".z"}, 32'(z), 32'(e.z));
        check({tag, ".n"}, 32'(n), 32'(e.n));
`ifdef ALU32_OVF_EN
        check({tag, ".v"}, 32'(v), 32'(e.v));
`endif
    endtask

    // Apply one op, check one cycle later, then disturb inputs and confirm outputs hold.
    task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_val,
                          input logic [2:0] ts);
        exp_t e;
        @(negedge clk);
        a   = ta;
        b   = tb_val;
        sel = ts;
        e   = model(ta, tb_val, ts);
        @(posedge clk);
        #1;
        check_all(tag, e);
        #2;
        a   = ~ta;
        b   = $urandom;
        sel = ts + 3'd1;
        #1;
        check({tag, ".hold"}, out, e.out);
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        e.out = 32'd0;
        e.c   = 1'b0;
        e.z   = 1'b1;
        e.n   = 1'b0;
        e.v   = 1'b0;
        check_all(tag, e);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] corner [4];
        corner[0] = 32'h0000_0000;
        corner[1] = 32'hFFFF_FFFF;
        corner[2] = 32'h8000_0000;
        corner[3] = 32'h7FFF_FFFF;

        rst_n = 1'b0;
        a     = 32'hFFFF_FFFF;
        b     = 32'h8000_0001;
        sel   = 3'd0;
        #12;
        check_reset("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("dir_sel%0d", i), 32'hFFFF_FFFF, 32'h8000_0001, 3'(i));

        run_op("ovf_add", 32'h7FFF_FFFF, 32'h0000_0001, 3'd0);
        run_op("ovf_sub", 32'h7FFF_FFFF, 32'h0000_0001, 3'd1);
        run_op("sll_zero", 32'h1234_5678, 32'h0000_0020, 3'd6);
        run_op("srl_zero", 32'h1234_5678, 32'h0000_0020, 3'd7);
        run_op("sll_31", 32'h0000_0003, 32'h0000_001F, 3'd6);
        run_op("srl_31", 32'hC000_0000, 32'hFFFF_FFFF, 3'd7);

        // Mid-run async reset: outputs must clear without a clock edge.
        run_op("pre_rst", 32'hFFFF_FFFF, 32'h8000_0001, 3'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("rst_async");
        @(posedge clk);
        #1;
        check_reset("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset("rst_release");

        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            run_op($sformatf("rnd%0d", i), ra, rb, 3'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
